// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit owning the HI/LO registers.
// Results are computed and captured at accept; a down-counter holds `busy`
// for MULT_CYCLES or DIV_CYCLES before HI/LO are written.
// Optional feature macro: MDU_MADD_EN (op 7 = signed multiply-accumulate).
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] res, res_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic        sdiv;
  logic [31:0] dvd, dvs, quo, rem, quo_fix, rem_fix;

  // Datapath: products and a sign-magnitude divider shared by DIV/DIVU.
  // Working on magnitudes makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'd0, a} * {32'd0, b};
    sdiv    = (op == OP_DIV);
    dvd     = (sdiv && a[31]) ? -a : a;
    dvs     = (sdiv && b[31]) ? -b : b;
    quo     = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    rem     = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    quo_fix = (sdiv && (a[31] ^ b[31])) ? -quo : quo;
    rem_fix = (sdiv && a[31]) ? -rem : rem;
  end

  // State, counter, captured result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      res   <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state: accept only from IDLE; count down and commit on cnt == 0.
  // Divide by zero captures the current HI/LO, so the commit is a no-op.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_nxt   = res;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  begin state_nxt = MUL; cnt_nxt = MULT_LOAD; res_nxt = prod_s; end
            OP_MULTU: begin state_nxt = MUL; cnt_nxt = MULT_LOAD; res_nxt = prod_u; end
            OP_DIV, OP_DIVU: begin
              state_nxt = DIV;
              cnt_nxt   = DIV_LOAD;
              res_nxt   = (b == 32'd0) ? {hi, lo} : {rem_fix, quo_fix};
            end
            OP_MTHI:  hi_nxt = a;
            OP_MTLO:  lo_nxt = a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin state_nxt = MUL; cnt_nxt = MULT_LOAD; res_nxt = {hi, lo} + prod_s; end
`endif
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          hi_nxt    = res[63:32];
          lo_nxt    = res[31:0];
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU and owning the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo requests and runs products and quotients over a fixed multi-cycle latency. It drives the `busy` flag that the hazard control logic combines with its D-stage HI/LO-instruction decode to stall the pipeline. It also supplies HI/LO values for mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu (and madd when compiled in); legal range 1–15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu; legal range 1–15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input 1: request valid this cycle; asserted by E stage for one cycle per instruction.
- `op` input 3: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (see Configuration).
- `a` input 32: rs operand (forwarded value).
- `b` input 32: rt operand (forwarded value).
- `busy` output 1: registered; high while a mult/div is in flight.
- `hi` output 32: registered HI register.
- `lo` output 32: registered LO register.

## Operation
- States are IDLE, MUL and DIV, with a 4-bit down-counter `cnt`.
- **Accept:** a request is accepted when `start`=1, the state is IDLE and `op`≠0. In any other state, `start` is ignored; the hazard logic guarantees it never occurs, and the bench checks that it is ignored.
- **MULT:** signed 32×32→64 product. HI = [63:32], LO = [31:0].
- **MULTU:** unsigned 32×32→64 product. HI = [63:32], LO = [31:0].
- **DIV:** signed divide. LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- **DIV special case:** 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **DIVU:** unsigned divide. LO = quotient, HI = remainder.
- **Divide by zero (`b`=0, DIV or DIVU):** HI and LO are left unchanged. `busy` is still held for the full DIV_CYCLES.
- **Operand capture:** on accept of MULT/MULTU/DIV/DIVU, operands and the full 64-bit result are captured. State goes to MUL or DIV and `cnt` is set to MULT_CYCLES-1 or DIV_CYCLES-1.
- **MUL/DIV states:** `cnt` decrements each cycle. On the edge where `cnt`=0, HI/LO are written with the captured result and the state returns to IDLE.
- **MTHI/MTLO:** accepted only in IDLE. HI (or LO) ← `a` on that edge. No busy period.
- **Simultaneous events:** none are possible, since only one request is accepted per cycle and only from IDLE.

## Timing
- **Reset:** `reset_n`=0 at a rising edge sets state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0.
- **Reset mid-operation:** applies the same reset values; the in-flight result is discarded.
- **Busy window:** for a request accepted at edge T0, `busy`=1 for exactly N cycles after T0, where N = MULT_CYCLES or DIV_CYCLES. It falls on the same edge at which HI/LO update.
- **Back-to-back requests:** a new request is accepted on the first cycle `busy`=0.
- **mfhi/mflo:** a read issued in the cycle `busy` first reads 0 sees the new HI/LO.
- **MTHI/MTLO:** the new value is visible on `hi`/`lo` the cycle after acceptance.
- **Stall relationship:** `busy` is not asserted in the accept cycle itself. The hazard logic stalls on start-of-mult/div-in-E OR `busy`, so it covers that cycle.
- **Outputs:** `hi`, `lo` and `busy` are purely registered, with no combinational path from inputs to outputs.

## Configuration
- **`MDU_MADD_EN` defined:**
  - op 7 is MADD: {HI,LO} ← {HI,LO} + signed(a)×signed(b), with 64-bit wrap-around.
  - The sum is computed from HI/LO as they stand at accept.
  - Latency is MULT_CYCLES, with the same busy behaviour as MULT.
- **`MDU_MADD_EN` undefined:** op 7 is treated as op 0. It is never accepted, HI/LO and `busy` are unaffected, and no adder logic is generated.

## Test plan
- Reset, then MULT with a=0xFFFFFFFE (-2), b=3 → `busy`=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Also checks `busy`=0 and HI/LO=0 right after reset.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV with a=-7 (0xFFFFFFF9), b=2 → after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU with a=7, b=2 → LO=3, HI=1.
- Divide-by-zero and MTHI/MTLO:
  - MTHI with a=0x12345678 → HI=0x12345678 next cycle, `busy` stays 0.
  - Then DIVU with b=0 → `busy` high for 10 cycles, HI=0x12345678 and LO unchanged.
- Abort and overlap (run once with `MDU_MADD_EN` defined and once undefined):
  - Pulse `reset_n`=0 on the 3rd busy cycle of a DIV → next cycle `busy`=0, HI=LO=0.
  - Assert `start` with op=MULT while busy → ignored.
  - With `MDU_MADD_EN`: HI:LO=0:5, then MADD 2×3 → LO=11.
  - Without `MDU_MADD_EN`: op 7 leaves everything unchanged.
